vehicle_classifier: RTL and testbench

Front-end stage that turns a raw vehicle-presence loop sensor into the classified vehicle stream (d_out/valid_out) consumed by the pattern-detector FSM.
It synchronises and debounces the sensor, then measures occupancy time per vehicle. Each vehicle is classified as bike (short occupancy) or car (long occupancy), and the block emits one single-cycle valid pulse per vehicle.
Glitches are rejected, and a stuck-high sensor is flagged as a fault.

---
 rtl/vehicle_pkg.sv | 16 +
 rtl/input_debouncer.sv | 68 ++++++
 rtl/vehicle_classifier.sv | 127 ++++++++++++
 tb/tb_vehicle_classifier.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vehicle_pkg.sv
// Shared definitions for the vehicle classifier front end: vehicle type
// codes (also used by the downstream pattern detector) and the classifier
// state encoding.
package vehicle_pkg;

  localparam logic VEH_BIKE = 1'b1;
  localparam logic VEH_CAR  = 1'b0;

  // Encoding 2'b11 is unused and falls back to IDLE in the classifier.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    OCCUPIED = 2'b01,
    FAULT    = 2'b10
  } cls_state_t;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a stable-sample debouncer. The filtered
// level only follows the synchronised input after it has disagreed with the
// current filtered level for DEBOUNCE_CYCLES consecutive cycles.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic filt_out
);

  localparam int SYNC_STAGES = 2;
  localparam int DBC_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_q;
  logic [DBC_W-1:0]       dbc_reg;
  logic                   filt_reg;

  // Synchroniser chain: stage 0 samples the asynchronous input, each later
  // stage re-times the previous one.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg[0] <= 1'b0;
    end else begin
      sync_reg[0] <= raw_in;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      // Re-time the previous synchroniser stage.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_reg[gi] <= 1'b0;
        end else begin
          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign sync_q = sync_reg[SYNC_STAGES-1];

  // Count consecutive disagreement cycles; flip the filtered level on the
  // last one, restart the count whenever input and filtered level agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbc_reg  <= '0;
      filt_reg <= 1'b0;
    end else if (sync_q != filt_reg) begin
      if (dbc_reg == DBC_LAST) begin
        filt_reg <= sync_q;
        dbc_reg  <= '0;
      end else begin
        dbc_reg <= dbc_reg + 1'b1;
      end
    end else begin
      dbc_reg <= '0;
    end
  end

  assign filt_out = filt_reg;

endmodule

// File: rtl/vehicle_classifier.sv
// Vehicle classifier: debounces the loop sensor, measures how long each
// vehicle occupies the loop and emits one registered valid pulse per
// vehicle tagged bike (short) or car (long). Short blips are dropped and a
// sensor held high for MAX_OCC cycles parks the block in FAULT until it
// drops again.
module vehicle_classifier
  import vehicle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16,
  parameter int MIN_OCC         = 8,
  parameter int BIKE_MAX        = 100,
  parameter int MAX_OCC         = 60000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_in,
  output logic             valid_out,
  output logic             d_out,
  output logic [CNT_W-1:0] occ_len,
  output logic             busy,
  output logic             fault
);

  localparam logic [CNT_W-1:0] MIN_OCC_C  = CNT_W'(MIN_OCC);
  localparam logic [CNT_W-1:0] BIKE_MAX_C = CNT_W'(BIKE_MAX);
  localparam logic [CNT_W-1:0] MAX_OCC_C  = CNT_W'(MAX_OCC);

  logic             filt;
  cls_state_t       state_reg, state_next;
  logic [CNT_W-1:0] occ_reg, occ_next, occ_inc;
  logic             valid_reg, valid_next;
  logic             d_reg, d_next;
  logic [CNT_W-1:0] occ_len_reg, occ_len_next;
  logic             busy_reg, fault_reg;

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk),
    .reset   (reset),
    .raw_in  (sensor_in),
    .filt_out(filt)
  );

  // MAX_OCC is below 2^CNT_W, and FAULT is entered on reaching it, so this
  // increment can never wrap.
  assign occ_inc = occ_reg + 1'b1;

  // State, occupancy counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      occ_reg     <= '0;
      valid_reg   <= 1'b0;
      d_reg       <= 1'b0;
      occ_len_reg <= '0;
      busy_reg    <= 1'b0;
      fault_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      occ_reg     <= occ_next;
      valid_reg   <= valid_next;
      d_reg       <= d_next;
      occ_len_reg <= occ_len_next;
      busy_reg    <= (state_next == OCCUPIED);
      fault_reg   <= (state_next == FAULT);
    end
  end

  // Next state and occupancy: count while occupied, trap in FAULT at the cap.
  always_comb begin
    state_next = state_reg;
    occ_next   = occ_reg;
    case (state_reg)
      IDLE: begin
        if (filt) begin
          state_next = OCCUPIED;
          occ_next   = CNT_W'(1);
        end else begin
          occ_next = '0;
        end
      end
      OCCUPIED: begin
        if (filt) begin
          occ_next = occ_inc;
          if (occ_inc == MAX_OCC_C) begin
            state_next = FAULT;
          end
        end else begin
          state_next = IDLE;
          occ_next   = '0;
        end
      end
      FAULT: begin
        if (!filt) begin
          state_next = IDLE;
          occ_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        occ_next   = '0;
      end
    endcase
  end

  // Classification on the cycle that leaves OCCUPIED; d_out/occ_len hold
  // their last values between pulses.
  always_comb begin
    valid_next   = 1'b0;
    d_next       = d_reg;
    occ_len_next = occ_len_reg;
    if ((state_reg == OCCUPIED) && !filt && (occ_reg >= MIN_OCC_C)) begin
      valid_next   = 1'b1;
      d_next       = (occ_reg <= BIKE_MAX_C) ? VEH_BIKE : VEH_CAR;
      occ_len_next = occ_reg;
    end
  end

  assign valid_out = valid_reg;
  assign d_out     = d_reg;
  assign occ_len   = occ_len_reg;
  assign busy      = busy_reg;
  assign fault     = fault_reg;

endmodule

// File: tb/tb_vehicle_classifier.sv
// Directed testbench for vehicle_classifier (DEBOUNCE_CYCLES=4, MIN_OCC=8,
// BIKE_MAX=100, MAX_OCC=200). Inputs change on the falling edge, outputs are
// sampled on the falling edge or 1 time unit after the rising edge.
module tb_vehicle_classifier;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             sensor_in;
  logic             valid_out;
  logic             d_out;
  logic [CNT_W-1:0] occ_len;
  logic             busy;
  logic             fault;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int   pulse_at[$];
  logic pulse_d[$];
  int   pulse_occ[$];

  vehicle_classifier #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (CNT_W),
    .MIN_OCC        (8),
    .BIKE_MAX       (100),
    .MAX_OCC        (200)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sensor_in(sensor_in),
    .valid_out(valid_out),
    .d_out    (d_out),
    .occ_len  (occ_len),
    .busy     (busy),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every classified vehicle, one line each.
  always @(posedge clk) begin
    #1;
    if (valid_out === 1'b1) begin
      pulse_at.push_back(cyc);
      pulse_d.push_back(d_out);
      pulse_occ.push_back(int'(occ_len));
      $display("pulse: cycle=%0d d_out=%0b occ_len=%0d", cyc, d_out, occ_len);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_pulses(input int target);
    for (int k = 0; k < 40 && pulse_at.size() < target; k++) @(negedge clk);
  endtask

  task automatic check_pulse(input string tag, input int idx, input logic exp_d,
                             input int exp_occ, input int drop);
    check({tag, "_present"}, 32'(pulse_at.size() > idx), 32'd1);
    if (pulse_at.size() > idx) begin
      check({tag, "_d_out"}, 32'(pulse_d[idx]), 32'(exp_d));
      check({tag, "_occ_len"}, 32'(pulse_occ[idx]), 32'(exp_occ));
      check({tag, "_latency"}, 32'(pulse_at[idx] - drop), 32'd7);
    end
  endtask

  task automatic vehicle(input string tag, input int w, input logic exp_d, input int exp_occ);
    int base;
    int drop;
    base = pulse_at.size();
    sensor_in = 1'b1;
    repeat (w) @(negedge clk);
    sensor_in = 1'b0;
    drop = cyc;
    wait_pulses(base + 1);
    check_pulse(tag, base, exp_d, exp_occ, drop);
    repeat (12) @(negedge clk);
    check({tag, "_count"}, 32'(pulse_at.size()), 32'(base + 1));
  endtask

  initial begin
    int   base;
    int   drop_a;
    int   drop_b;
    logic seen;

    reset     = 1'b1;
    sensor_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_d_out", 32'(d_out), 32'd0);
    check("rst_occ_len", 32'(occ_len), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: bike, 50 cycles; busy rises 7 edges after the first high sample
    base = pulse_at.size();
    sensor_in = 1'b1;
    repeat (6) @(negedge clk);
    check("t1_busy_before", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_busy_during", 32'(busy), 32'd1);
    repeat (43) @(negedge clk);
    sensor_in = 1'b0;
    drop_a = cyc;
    wait_pulses(base + 1);
    check_pulse("t1_bike50", base, 1'b1, 50, drop_a);
    repeat (12) @(negedge clk);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_count", 32'(pulse_at.size()), 32'(base + 1));

    // 2: car 150, 4-cycle gap, bike 20
    base = pulse_at.size();
    sensor_in = 1'b1;
    repeat (150) @(negedge clk);
    sensor_in = 1'b0;
    drop_a = cyc;
    repeat (4) @(negedge clk);
    sensor_in = 1'b1;
    repeat (20) @(negedge clk);
    sensor_in = 1'b0;
    drop_b = cyc;
    wait_pulses(base + 2);
    check_pulse("t2_car150", base, 1'b0, 150, drop_a);
    check_pulse("t2_bike20", base + 1, 1'b1, 20, drop_b);
    repeat (12) @(negedge clk);
    check("t2_count", 32'(pulse_at.size()), 32'(base + 2));

    // 3a: 3-cycle glitch never reaches the filtered level
    base = pulse_at.size();
    sensor_in = 1'b1;
    repeat (3) @(negedge clk);
    sensor_in = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      seen = seen | busy;
    end
    check("t3a_busy_seen", 32'(seen), 32'd0);
    check("t3a_count", 32'(pulse_at.size()), 32'(base));

    // 3b: 6-cycle blip enters OCCUPIED but is discarded
    sensor_in = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | busy;
    end
    sensor_in = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      seen = seen | busy;
    end
    check("t3b_busy_seen", 32'(seen), 32'd1);
    check("t3b_count", 32'(pulse_at.size()), 32'(base));

    // 3c: two 2-cycle dropouts inside a 120-cycle span
    sensor_in = 1'b1;
    repeat (40) @(negedge clk);
    sensor_in = 1'b0;
    repeat (2) @(negedge clk);
    sensor_in = 1'b1;
    repeat (38) @(negedge clk);
    sensor_in = 1'b0;
    repeat (2) @(negedge clk);
    sensor_in = 1'b1;
    repeat (38) @(negedge clk);
    sensor_in = 1'b0;
    drop_a = cyc;
    wait_pulses(base + 1);
    check_pulse("t3c_car120", base, 1'b0, 120, drop_a);
    repeat (12) @(negedge clk);
    check("t3c_count", 32'(pulse_at.size()), 32'(base + 1));

    // 4: classification boundaries
    vehicle("t4_bike8", 8, 1'b1, 8);
    vehicle("t4_bike100", 100, 1'b1, 100);
    vehicle("t4_car101", 101, 1'b0, 101);

    // 5: stuck sensor reaches the cap and faults, then recovers
    base = pulse_at.size();
    sensor_in = 1'b1;
    repeat (205) @(negedge clk);
    check("t5_busy_occ199", 32'(busy), 32'd1);
    check("t5_fault_occ199", 32'(fault), 32'd0);
    @(negedge clk);
    check("t5_fault_occ200", 32'(fault), 32'd1);
    check("t5_busy_occ200", 32'(busy), 32'd0);
    repeat (44) @(negedge clk);
    check("t5_fault_held", 32'(fault), 32'd1);
    sensor_in = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_fault_before_clear", 32'(fault), 32'd1);
    @(negedge clk);
    check("t5_fault_cleared", 32'(fault), 32'd0);
    repeat (10) @(negedge clk);
    check("t5_no_pulse", 32'(pulse_at.size()), 32'(base));
    vehicle("t5_bike30", 30, 1'b1, 30);

    // 6: reset on the 40th high cycle of a 90-cycle vehicle
    base = pulse_at.size();
    sensor_in = 1'b1;
    repeat (39) @(negedge clk);
    check("t6_busy_pre_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_rst_valid", 32'(valid_out), 32'd0);
    check("t6_rst_d_out", 32'(d_out), 32'd0);
    check("t6_rst_occ_len", 32'(occ_len), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_fault", 32'(fault), 32'd0);
    repeat (50) @(negedge clk);
    sensor_in = 1'b0;
    drop_a = cyc;
    wait_pulses(base + 1);
    check_pulse("t6_bike50", base, 1'b1, 50, drop_a);
    repeat (12) @(negedge clk);
    check("t6_count", 32'(pulse_at.size()), 32'(base + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
